// File: rtl/branch_resolve_checker_pkg.sv
// Shared types for the branch resolve checker: queue entry, FSM encoding and PC constants.
package branch_pkg;

    localparam logic [63:0] INSTR_BYTES   = 64'd4;
    localparam logic [63:0] NO_PREDICTION = 64'd0;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] pred;
    } pred_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } resolve_state_t;

endpackage

// File: rtl/branch_resolve_checker_if.sv
// Fetch/resolve/update bus between the pipeline (master) and the branch resolve checker (slave).
interface branch_resolve_checker_if;

    logic        en;
    logic        fetch_valid;
    logic [63:0] fetch_pc;
    logic [63:0] fetch_pred_pc;
    logic        queue_full;
    logic        resolve_valid;
    logic [63:0] resolve_pc;
    logic        resolve_taken;
    logic        resolve_is_jump;
    logic [63:0] resolve_target;
    logic        flush;
    logic [63:0] redirect_pc;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic [63:0] upd_target;
    logic        upd_taken;
    logic        upd_jumped;
    logic        err_underflow;

    modport master (
        output en, fetch_valid, fetch_pc, fetch_pred_pc,
        output resolve_valid, resolve_pc, resolve_taken, resolve_is_jump, resolve_target,
        input  queue_full, flush, redirect_pc,
        input  upd_valid, upd_pc, upd_target, upd_taken, upd_jumped, err_underflow
    );

    modport slave (
        input  en, fetch_valid, fetch_pc, fetch_pred_pc,
        input  resolve_valid, resolve_pc, resolve_taken, resolve_is_jump, resolve_target,
        output queue_full, flush, redirect_pc,
        output upd_valid, upd_pc, upd_target, upd_taken, upd_jumped, err_underflow
    );

endinterface

// File: rtl/branch_resolve_checker_pred_queue.sv
// pred_queue: circular FIFO of in-flight predictions with push, pop and whole-queue clear.
module pred_queue
    import branch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  pred_entry_t push_entry,
    output logic        full,
    output logic        empty,
    output pred_entry_t head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    pred_entry_t   mem [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic [CW-1:0] count;

    logic do_push;
    logic do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[head_ptr];
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail_ptr] <= push_entry;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural overflow of PW bits.
    always_ff @(posedge clk) begin
        if (!arst_n || clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                tail_ptr <= tail_ptr + PW'(1);
            end
            if (do_pop) begin
                head_ptr <= head_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_checker.sv
// Execute-side branch prediction checker: flush/redirect on mispredict, BTB update writes.
// Optional BRANCH_RESOLVE_STATS_EN adds saturating resolve/mispredict counters.
//
//   state | meaning
//   RUN   | accepting pushes and resolves, comparing predictions
//   FLUSH | post-mispredict drain; pushes and resolves ignored until timer expires
module branch_resolve_checker
    import branch_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    arst_n,
    branch_resolve_checker_if.slave bus
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [31:0]             stat_resolved,
    output logic [31:0]             stat_mispredict
`endif
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

    resolve_state_t state_q, state_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;

    pred_entry_t head;
    pred_entry_t push_entry;
    logic        q_full;
    logic        q_empty;

    logic        in_run;
    logic        push_req;
    logic        resolve_req;
    logic        pop;
    logic        underflow;
    logic        mispredict;
    logic        is_redirect;
    logic [63:0] actual_pc;
    logic [63:0] pred_pc;

    assign in_run      = (state_q == RUN);
    assign push_req    = bus.fetch_valid & bus.en & in_run;
    assign resolve_req = bus.resolve_valid & bus.en & in_run;
    assign pop         = resolve_req & ~q_empty;
    assign underflow   = resolve_req & q_empty;

    assign is_redirect = bus.resolve_taken | bus.resolve_is_jump;
    assign actual_pc   = is_redirect ? bus.resolve_target : bus.resolve_pc + INSTR_BYTES;
    assign pred_pc     = (head.pred != NO_PREDICTION) ? head.pred : head.pc + INSTR_BYTES;
    assign mispredict  = pop & ((pred_pc != actual_pc) | (head.pc != bus.resolve_pc));

    assign push_entry.pc   = bus.fetch_pc;
    assign push_entry.pred = bus.fetch_pred_pc;
    assign bus.queue_full  = q_full;

    // A mispredict clears the queue and takes priority over any same-cycle push.
    pred_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .arst_n     (arst_n),
        .push       (push_req & ~mispredict),
        .pop        (pop & ~mispredict),
        .clear      (mispredict),
        .push_entry (push_entry),
        .full       (q_full),
        .empty      (q_empty),
        .head       (head)
    );

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            RUN: begin
                if (mispredict) begin
                    state_d = FLUSH;
                    fcnt_d  = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (bus.en) begin
                    if (fcnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        fcnt_d = fcnt_q - FCW'(1);
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Pulses drop whenever en is low; data registers hold their last value.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            bus.flush         <= 1'b0;
            bus.redirect_pc   <= '0;
            bus.upd_valid     <= 1'b0;
            bus.upd_pc        <= '0;
            bus.upd_target    <= '0;
            bus.upd_taken     <= 1'b0;
            bus.upd_jumped    <= 1'b0;
            bus.err_underflow <= 1'b0;
        end else begin
            bus.flush     <= mispredict;
            bus.upd_valid <= pop & is_redirect;
            if (mispredict) begin
                bus.redirect_pc <= actual_pc;
            end
            if (pop & is_redirect) begin
                bus.upd_pc     <= bus.resolve_pc;
                bus.upd_target <= bus.resolve_target;
                bus.upd_taken  <= bus.resolve_taken;
                bus.upd_jumped <= bus.resolve_is_jump;
            end
            if (underflow) begin
                bus.err_underflow <= 1'b1;
            end
        end
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            stat_resolved   <= '0;
            stat_mispredict <= '0;
        end else begin
            if (pop && stat_resolved != 32'hFFFF_FFFF) begin
                stat_resolved <= stat_resolved + 32'd1;
            end
            if (mispredict && stat_mispredict != 32'hFFFF_FFFF) begin
                stat_mispredict <= stat_mispredict + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_checker.sv
// Directed self-checking bench for branch_resolve_checker (stats checked when BRANCH_RESOLVE_STATS_EN is set).
module tb_branch_resolve_checker;

    logic clk;
    logic arst_n;
    int   checks;
    int   errors;

    branch_resolve_checker_if bus ();

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] stat_resolved;
    logic [31:0] stat_mispredict;
`endif

    branch_resolve_checker #(.DEPTH(8), .FLUSH_CYCLES(2)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
`ifdef BRANCH_RESOLVE_STATS_EN
        ,
        .stat_resolved   (stat_resolved),
        .stat_mispredict (stat_mispredict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.en              = 1'b1;
        bus.fetch_valid     = 1'b0;
        bus.fetch_pc        = '0;
        bus.fetch_pred_pc   = '0;
        bus.resolve_valid   = 1'b0;
        bus.resolve_pc      = '0;
        bus.resolve_taken   = 1'b0;
        bus.resolve_is_jump = 1'b0;
        bus.resolve_target  = '0;
    endtask

    task automatic push(input logic [63:0] pc, input logic [63:0] pred);
        bus.fetch_valid   = 1'b1;
        bus.fetch_pc      = pc;
        bus.fetch_pred_pc = pred;
        tick();
        bus.fetch_valid   = 1'b0;
    endtask

    task automatic resolve(input logic [63:0] pc, input logic taken, input logic jump,
                           input logic [63:0] target);
        bus.resolve_valid   = 1'b1;
        bus.resolve_pc      = pc;
        bus.resolve_taken   = taken;
        bus.resolve_is_jump = jump;
        bus.resolve_target  = target;
        tick();
        bus.resolve_valid   = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        arst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.flush !== 1'b0 || bus.redirect_pc !== 64'd0) begin
            errors++;
            $display("FAIL reset_flush: flush=%b redirect=%h expected 0/0", bus.flush, bus.redirect_pc);
        end
        checks++;
        if (bus.upd_valid !== 1'b0 || bus.upd_pc !== 64'd0 || bus.upd_target !== 64'd0 ||
            bus.upd_taken !== 1'b0 || bus.upd_jumped !== 1'b0) begin
            errors++;
            $display("FAIL reset_upd: upd_valid=%b upd_pc=%h expected all 0", bus.upd_valid, bus.upd_pc);
        end
        checks++;
        if (bus.err_underflow !== 1'b0 || bus.queue_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_err_full: err=%b full=%b expected 0/0", bus.err_underflow, bus.queue_full);
        end
        arst_n = 1'b1;
    endtask

    task automatic test_correct_predict();
        push(64'h100, 64'h200);
        resolve(64'h100, 1'b1, 1'b0, 64'h200);
        checks++;
        if (bus.flush !== 1'b0 || bus.upd_valid !== 1'b1 || bus.upd_pc !== 64'h100 ||
            bus.upd_target !== 64'h200 || bus.upd_taken !== 1'b1 || bus.upd_jumped !== 1'b0) begin
            errors++;
            $display("FAIL taken_hit: flush=%b upd_valid=%b upd_pc=%h upd_target=%h taken=%b jumped=%b expected 0/1/100/200/1/0",
                     bus.flush, bus.upd_valid, bus.upd_pc, bus.upd_target, bus.upd_taken, bus.upd_jumped);
        end
        tick();
        checks++;
        if (bus.upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL upd_pulse_width: upd_valid=%b expected 0", bus.upd_valid);
        end
        push(64'h300, 64'h800);
        resolve(64'h300, 1'b0, 1'b1, 64'h800);
        checks++;
        if (bus.flush !== 1'b0 || bus.upd_valid !== 1'b1 || bus.upd_taken !== 1'b0 ||
            bus.upd_jumped !== 1'b1 || bus.upd_target !== 64'h800) begin
            errors++;
            $display("FAIL jump_hit: flush=%b upd_valid=%b taken=%b jumped=%b target=%h expected 0/1/0/1/800",
                     bus.flush, bus.upd_valid, bus.upd_taken, bus.upd_jumped, bus.upd_target);
        end
        push(64'h500, 64'h0);
        resolve(64'h500, 1'b0, 1'b0, 64'h0);
        checks++;
        if (bus.flush !== 1'b0 || bus.upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL fallthrough_hit: flush=%b upd_valid=%b expected 0/0", bus.flush, bus.upd_valid);
        end
    endtask

    task automatic test_mispredict_taken();
        push(64'h100, 64'h0);
        resolve(64'h100, 1'b1, 1'b0, 64'h300);
        checks++;
        if (bus.flush !== 1'b1 || bus.redirect_pc !== 64'h300 || bus.upd_valid !== 1'b1) begin
            errors++;
            $display("FAIL mispredict_taken: flush=%b redirect=%h upd_valid=%b expected 1/300/1",
                     bus.flush, bus.redirect_pc, bus.upd_valid);
        end
        bus.fetch_valid   = 1'b1;
        bus.fetch_pc      = 64'h900;
        bus.fetch_pred_pc = 64'h0;
        tick();
        checks++;
        if (bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL flush_pulse_width: flush=%b expected 0", bus.flush);
        end
        tick();
        bus.fetch_valid = 1'b0;
        // Both the mispredicted entry and the fetches during FLUSH must be gone.
        push(64'hA00, 64'h0);
        resolve(64'hA00, 1'b0, 1'b0, 64'h0);
        checks++;
        if (bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL flush_drops_fetch: flush=%b expected 0", bus.flush);
        end
    endtask

    task automatic test_mispredict_not_taken();
        push(64'h100, 64'h200);
        resolve(64'h100, 1'b0, 1'b0, 64'h0);
        checks++;
        if (bus.flush !== 1'b1 || bus.redirect_pc !== 64'h104 || bus.upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL mispredict_not_taken: flush=%b redirect=%h upd_valid=%b expected 1/104/0",
                     bus.flush, bus.redirect_pc, bus.upd_valid);
        end
        tick();
        tick();
        push(64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
        resolve(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 64'h0);
        checks++;
        if (bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL pc_wrap: flush=%b expected 0", bus.flush);
        end
`ifdef BRANCH_RESOLVE_STATS_EN
        checks++;
        if (stat_mispredict !== 32'd2 || stat_resolved !== 32'd7) begin
            errors++;
            $display("FAIL stats: mispredict=%0d resolved=%0d expected 2/7", stat_mispredict, stat_resolved);
        end
`endif
    endtask

    task automatic test_full_wrap();
        int bad;
        for (int i = 0; i < 8; i++) begin
            push(64'h1000 + 64'(i) * 64'h10, 64'h0);
        end
        checks++;
        if (bus.queue_full !== 1'b1) begin
            errors++;
            $display("FAIL full_after_8: queue_full=%b expected 1", bus.queue_full);
        end
        push(64'h2000, 64'h0);
        checks++;
        if (bus.queue_full !== 1'b1) begin
            errors++;
            $display("FAIL full_9th_push: queue_full=%b expected 1", bus.queue_full);
        end
        // Full blocks the push even with a same-cycle pop, so count drops to 7.
        bus.fetch_valid   = 1'b1;
        bus.fetch_pc      = 64'h2000;
        bus.fetch_pred_pc = 64'h0;
        resolve(64'h1000, 1'b0, 1'b0, 64'h0);
        checks++;
        if (bus.queue_full !== 1'b0 || bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop: full=%b flush=%b expected 0/0", bus.queue_full, bus.flush);
        end
        bus.fetch_pc = 64'h3000;
        resolve(64'h1010, 1'b0, 1'b0, 64'h0);
        bus.fetch_valid = 1'b0;
        checks++;
        if (bus.queue_full !== 1'b0 || bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL push_pop_count: full=%b flush=%b expected 0/0", bus.queue_full, bus.flush);
        end
        push(64'h3010, 64'h0);
        checks++;
        if (bus.queue_full !== 1'b1) begin
            errors++;
            $display("FAIL refill: queue_full=%b expected 1", bus.queue_full);
        end
        bad = 0;
        for (int i = 2; i < 8; i++) begin
            resolve(64'h1000 + 64'(i) * 64'h10, 1'b0, 1'b0, 64'h0);
            if (bus.flush !== 1'b0) bad++;
        end
        resolve(64'h3000, 1'b0, 1'b0, 64'h0);
        if (bus.flush !== 1'b0) bad++;
        resolve(64'h3010, 1'b0, 1'b0, 64'h0);
        if (bus.flush !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL drain_order: %0d flushes expected 0", bad);
        end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            push(64'h5000 + 64'(i) * 64'h8, 64'h7000 + 64'(i));
            resolve(64'h5000 + 64'(i) * 64'h8, 1'b1, 1'b0, 64'h7000 + 64'(i));
            if (bus.flush !== 1'b0 || bus.upd_pc !== 64'h5000 + 64'(i) * 64'h8) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL pointer_wrap: %0d bad resolves expected 0", bad);
        end
    endtask

    task automatic test_underflow_reset();
        bus.fetch_valid   = 1'b1;
        bus.fetch_pc      = 64'h700;
        bus.fetch_pred_pc = 64'h0;
        resolve(64'h700, 1'b1, 1'b0, 64'h900);
        bus.fetch_valid = 1'b0;
        checks++;
        if (bus.err_underflow !== 1'b1 || bus.flush !== 1'b0 || bus.upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL underflow: err=%b flush=%b upd_valid=%b expected 1/0/0",
                     bus.err_underflow, bus.flush, bus.upd_valid);
        end
        resolve(64'h700, 1'b0, 1'b0, 64'h0);
        checks++;
        if (bus.flush !== 1'b0 || bus.err_underflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow_push_kept: flush=%b err=%b expected 0/1", bus.flush, bus.err_underflow);
        end
        push(64'h100, 64'h200);
        resolve(64'h100, 1'b0, 1'b0, 64'h0);
        checks++;
        if (bus.flush !== 1'b1 || bus.err_underflow !== 1'b1) begin
            errors++;
            $display("FAIL sticky_err: flush=%b err=%b expected 1/1", bus.flush, bus.err_underflow);
        end
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
        checks++;
        if (bus.flush !== 1'b0 || bus.redirect_pc !== 64'd0 || bus.err_underflow !== 1'b0 ||
            bus.upd_valid !== 1'b0 || bus.upd_pc !== 64'd0) begin
            errors++;
            $display("FAIL reset_in_flush: flush=%b redirect=%h err=%b upd_valid=%b upd_pc=%h expected all 0",
                     bus.flush, bus.redirect_pc, bus.err_underflow, bus.upd_valid, bus.upd_pc);
        end
        push(64'h180, 64'h0);
        resolve(64'h180, 1'b0, 1'b0, 64'h0);
        checks++;
        if (bus.flush !== 1'b0 || bus.err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL run_after_reset: flush=%b err=%b expected 0/0", bus.flush, bus.err_underflow);
        end
    endtask

    task automatic test_stall();
        push(64'h100, 64'h200);
        push(64'h140, 64'h0);
        resolve(64'h100, 1'b1, 1'b0, 64'h200);
        bus.en              = 1'b0;
        bus.fetch_valid     = 1'b1;
        bus.fetch_pc        = 64'h900;
        bus.resolve_valid   = 1'b1;
        bus.resolve_pc      = 64'h140;
        bus.resolve_taken   = 1'b1;
        bus.resolve_target  = 64'h999;
        tick();
        checks++;
        if (bus.upd_valid !== 1'b0 || bus.flush !== 1'b0 || bus.upd_pc !== 64'h100) begin
            errors++;
            $display("FAIL stall_pulses: upd_valid=%b flush=%b upd_pc=%h expected 0/0/100",
                     bus.upd_valid, bus.flush, bus.upd_pc);
        end
        tick();
        checks++;
        if (bus.flush !== 1'b0 || bus.err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: flush=%b err=%b expected 0/0", bus.flush, bus.err_underflow);
        end
        idle();
        resolve(64'h140, 1'b0, 1'b0, 64'h0);
        push(64'h180, 64'h0);
        resolve(64'h180, 1'b0, 1'b0, 64'h0);
        checks++;
        if (bus.flush !== 1'b0 || bus.err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL stall_no_push: flush=%b err=%b expected 0/0", bus.flush, bus.err_underflow);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        arst_n = 1'b0;
        idle();
        test_reset();
        test_correct_predict();
        test_mispredict_taken();
        test_mispredict_not_taken();
        test_full_wrap();
        test_underflow_reset();
        test_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
